truth_table_checker: RTL

- Hardware response side of the exhaustive truth-table benches used in the lab flow.
- Drives every input vector of a combinational DUT (MSB = A … LSB = D), holds each vector for a fixed settle time, samples the DUT output and compares it with an expected truth-table mask.
- Reports the mismatch count, the first failing vector, and pass/done, so a combinational lab block can be verified on-board without a simulator.

---
 rtl/truth_table_checker.sv | 89 ++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker: applies every input vector to a combinational DUT and checks F against EXP_MASK.
// Define TT_CHECKER_STOP_ON_ERR_EN to end a run at the first mismatching sample.
module truth_table_checker #(
    parameter int N_IN = 4,
    parameter int HOLD_CYCLES = 20,
    parameter logic [2**N_IN-1:0] EXP_MASK = 16'h6996
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            f_in,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_n;
    logic [HW-1:0] h, h_n;
    logic [N_IN-1:0] vec_n, fev_n;
    logic [N_IN:0] err_n;
    logic fev_valid_n, sample, miss, stop;

    // F is only trusted on the last cycle of the hold window
    assign sample = state == RUN && h == H_LAST;
    assign miss = sample && (f_in !== EXP_MASK[vec_out]);
`ifdef TT_CHECKER_STOP_ON_ERR_EN
    assign stop = miss;
`else
    assign stop = 1'b0;
`endif
    assign busy = state == RUN;
    assign done = state == DONE;
    assign pass = done && err_count == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            h <= '0;
            vec_out <= '0;
            err_count <= '0;
            first_err_vec <= '0;
            first_err_valid <= 1'b0;
        end else begin
            state <= state_n;
            h <= h_n;
            vec_out <= vec_n;
            err_count <= err_n;
            first_err_vec <= fev_n;
            first_err_valid <= fev_valid_n;
        end
    end

    always_comb begin
        state_n = state;
        h_n = h;
        vec_n = vec_out;
        err_n = err_count;
        fev_n = first_err_vec;
        fev_valid_n = first_err_valid;
        if (state != RUN && start) begin
            state_n = RUN;
            h_n = '0;
            vec_n = '0;
            err_n = '0;
            fev_n = '0;
            fev_valid_n = 1'b0;
        end else if (state == RUN) begin
            h_n = h + 1'b1;
            if (miss) begin
                err_n = err_count + 1'b1;
                fev_n = first_err_valid ? first_err_vec : vec_out;
                fev_valid_n = 1'b1;
            end
            if (sample) begin
                h_n = '0;
                state_n = (stop || vec_out == '1) ? DONE : RUN;
                vec_n = (stop || vec_out == '1) ? vec_out : vec_out + 1'b1;
            end
        end
    end
endmodule
